// File: rtl/qpmm_pkg.sv
// rtl/qpmm_pkg.sv - shared constants, tag type and helpers for the QPMM issue sequencer
package qpmm_pkg;

  localparam int ADDR_W   = 8;
  localparam int RAM_LAT  = 3;
  localparam int QPMM_LAT = 32;
  localparam int PIPE_LAT = 1 + RAM_LAT + QPMM_LAT;
  localparam int CNT_W    = $clog2(PIPE_LAT + 1);

  // Tag stage whose valid bit marks A/B arriving at the multiplier inputs.
  localparam int OPV_STAGE = 1 + RAM_LAT - 1;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] dst;
  } qpmm_tag_t;

  // True when a live tag will write back to either source address.
  function automatic logic tag_hit(input qpmm_tag_t t,
                                   input logic [ADDR_W-1:0] src_a,
                                   input logic [ADDR_W-1:0] src_b);
    return t.v && ((t.dst == src_a) || (t.dst == src_b));
  endfunction

endpackage

// File: rtl/qpmm_issue_seq_if.sv
// rtl/qpmm_issue_seq_if.sv - command and RAM/write-back control bundle of the issue sequencer
interface qpmm_issue_seq_if;

  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [qpmm_pkg::ADDR_W-1:0]       cmd_src_a;
  logic [qpmm_pkg::ADDR_W-1:0]       cmd_src_b;
  logic [qpmm_pkg::ADDR_W-1:0]       cmd_dst;
  logic [qpmm_pkg::ADDR_W-1:0]       ram0_raddr;
  logic [qpmm_pkg::ADDR_W-1:0]       ram1_raddr;
  logic                              op_valid;
  logic [qpmm_pkg::ADDR_W-1:0]       wb_addr;
  logic                              wb_we;
  logic [qpmm_pkg::CNT_W-1:0]        inflight_cnt;
  logic                              busy;

  // Command producer side.
  modport master (
    output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready, ram0_raddr, ram1_raddr, op_valid, wb_addr, wb_we, inflight_cnt, busy
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready, ram0_raddr, ram1_raddr, op_valid, wb_addr, wb_we, inflight_cnt, busy
  );

endinterface

// File: rtl/qpmm_tag_pipe.sv
// rtl/qpmm_tag_pipe.sv - PIPE_LAT-deep tag shift register with every stage exposed
module qpmm_tag_pipe
  import qpmm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  qpmm_tag_t                tag_in,
  output qpmm_tag_t [PIPE_LAT-1:0] stages
);

  // Shift one stage per cycle; index 0 is the newest tag, reset clears every valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[PIPE_LAT-2:0], tag_in};
    end
  end

endmodule

// File: rtl/qpmm_issue_seq.sv
// rtl/qpmm_issue_seq.sv - QPMM command sequencer; optional RAW interlock under QPMM_ISSUE_HAZARD_EN
module qpmm_issue_seq
  import qpmm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  qpmm_issue_seq_if.slave bus
);

  qpmm_tag_t [PIPE_LAT-1:0] stages;
  qpmm_tag_t                tag_in;
  logic                     hazard;
  logic                     accept;
  logic                     retire;
  logic [ADDR_W-1:0]        ram0_raddr_q;
  logic [ADDR_W-1:0]        ram1_raddr_q;
  logic [CNT_W-1:0]         cnt_q;

`ifdef QPMM_ISSUE_HAZARD_EN
  // Stall while any pending product (not the one writing back this cycle) targets a source address.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      if (tag_hit(stages[i], bus.cmd_src_a, bus.cmd_src_b)) begin
        hazard = 1'b1;
      end
    end
  end
`else
  // Software spaces dependent commands, so the pipe is never inspected for conflicts.
  assign hazard = 1'b0;
  logic unused_tags;
  assign unused_tags = ^stages;
`endif

  assign bus.cmd_ready = !rst && !hazard;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign retire        = stages[PIPE_LAT-1].v;

  // Accepted commands enter the pipe as live tags, idle cycles as bubbles.
  always_comb begin
    tag_in.v   = accept;
    tag_in.dst = accept ? bus.cmd_dst : '0;
  end

  qpmm_tag_pipe u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .stages (stages)
  );

  // Read addresses follow the latest accepted command and hold in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram0_raddr_q <= '0;
      ram1_raddr_q <= '0;
    end else if (accept) begin
      ram0_raddr_q <= bus.cmd_src_a;
      ram1_raddr_q <= bus.cmd_src_b;
    end
  end

  // Count products between accept and write-back; simultaneous accept and retire cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.ram0_raddr   = ram0_raddr_q;
  assign bus.ram1_raddr   = ram1_raddr_q;
  assign bus.op_valid     = stages[OPV_STAGE].v;
  assign bus.wb_we        = stages[PIPE_LAT-1].v;
  assign bus.wb_addr      = stages[PIPE_LAT-1].dst;
  assign bus.inflight_cnt = cnt_q;
  assign bus.busy         = (cnt_q != '0);

endmodule
